dac_spi_receiver: RTL and testbench
===================================

// Module: dac_spi_receiver
// PURPOSE
//  - Receive end of the DAC serial link: oversamples spi_sclk/spi_cs_n/spi_mosi plus dac_clr_n/dac_ldac_n on clk.
//  - Rebuilds the 16-bit DAC frame and models the DAC's two-stage register: an input latch and an output latch.
//  - Presents the output latch as an Avalon-ST source, for loopback test of the DAC path and as a DAC stand-in on GPIO.
// PARAMETERS
//  FRAME_BITS   16  bits per frame; MSB first; [15:12] command, [11:0] data
//  DATA_BITS    12  data field width = ast_source_data width
//  SYNC_STAGES  2   flops per input synchronizer (>=2)
// PORTS
//  clk               in   1   oversampling clock; must be >= 2.5x spi_sclk (50 MHz system clock)
//  reset             in   1   asynchronous, active-high
//  spi_sclk          in   1   serial clock from the transmitter; data sampled on its rising edge
//  spi_cs_n          in   1   frame enable, active low
//  spi_mosi          in   1   serial data, MSB first
//  dac_clr_n         in   1   clear, active low, level-sensitive
//  dac_ldac_n        in   1   load output latch, active low
//  ast_source_data   out  12  output-latch value
//  ast_source_valid  out  1   1-clk pulse per output-latch update or framing error
//  ast_source_error  out  2   00 ok, 01 frame-length error, 10 clear event; qualified by valid
//  cmd               out  4   command nibble of the last accepted frame
//  overrun           out  1   sticky: frame accepted while input latch still pending; cleared only by reset
// BEHAVIOUR
//  - Reset values: all outputs 0; input latch 0; pending 0; shift reg 0; count 0; FSM WAIT_IDLE.
//  - Inputs: SYNC_STAGES-flop synchronizers; sync flops reset to 1 for spi_cs_n, dac_clr_n and dac_ldac_n.
//  - Edges: one extra register stage detects sclk rise, cs_n fall/rise and ldac_n fall.
//  - FSM:
//    - WAIT_IDLE: stays until synced cs_n==1, then IDLE. A reset released mid-frame therefore never captures a partial frame.
//    - IDLE: cs_n fall -> SHIFT; clear shift reg and count.
//    - SHIFT, on each sclk rise:
//      - shift <= {shift[FRAME_BITS-2:0], mosi}.
//      - count increments and saturates at FRAME_BITS+1 (5-bit counter).
//    - SHIFT, on cs_n rise -> IDLE, then:
//      - count==FRAME_BITS: accept frame. input latch <= shift[11:0]; cmd <= shift[15:12].
//        - If pending was already 1, set overrun.
//        - Set pending.
//      - Otherwise: reject frame. Pulse valid with error=01; data holds the current output latch; no latch changes.
//  - Load, either of:
//    - ldac_n fall seen while pending==1.
//    - Frame accepted while synced ldac_n==0 (tied-low mode).
//    - Effect: output latch <= input latch; pending <= 0; valid pulse with error=00, 1 clk after the trigger cycle.
//    - ldac_n fall with pending==0: no action, no pulse.
//  - Clear: while synced dac_clr_n==0, output latch, input latch and pending are held at 0.
//    - Falling edge of clr_n gives one valid pulse with error=10, data=0.
//    - The shift FSM keeps running; a frame finishing during clear is accepted, but its latch write is overridden by clear.
//  - Simultaneous events in one clk, priority clear > frame-length error > load.
//    - The lower-priority pulse is dropped. The load effect still happens unless clear is active.
//  - Latency, pin change to ast_source_valid: SYNC_STAGES+2 clk.
//    - The SYNC_STAGES+2 figure is measured for ldac_n fall, clr_n fall, or cs_n rise with tied-low ldac_n.
//  - A cs_n rise while in IDLE or WAIT_IDLE is ignored. sclk rises outside SHIFT are ignored.
// TESTING
//  - Frame 0x3A5C, ldac_n high; then ldac_n pulse low 4 clk.
//    -> cmd=0x3 at cs_n rise; no valid until ldac.
//    -> Then one valid: data=0xA5C, error=00, at SYNC_STAGES+2 clk after the ldac_n fall.
//  - ldac_n tied 0; frames 0x0123 then 0x0FFF.
//    -> Two valid pulses: 0x123 then 0xFFF, error=00; overrun stays 0.
//  - 15-bit frame, then 17-bit frame.
//    -> Each gives one valid: error=01, data unchanged (0x000 after reset); cmd unchanged.
//  - Two accepted frames with no ldac between them.
//    -> overrun=1.
//    -> After an ldac pulse, data = second frame's data; overrun stays 1.
//  - clr_n low while pending, then ldac_n fall in the same clk.
//    -> Single valid: error=10, data=0; pending cleared; the later ldac gives no pulse.
//  - reset asserted mid-frame (bit 7), released while cs_n still low; cs_n rises; then a full frame 0x0800.
//    -> No valid from the broken frame; 0x800 is accepted normally.

Source files
------------

// File: rtl/dac_spi_receiver.sv
// Receive end of the DAC serial link. Oversamples the SPI pins and the DAC
// control pins on clk, rebuilds 16-bit frames and models the DAC's
// input-latch / output-latch pair. Output-latch updates, framing errors and
// clear events are reported on an Avalon-ST source.
module dac_spi_receiver #(
  parameter int FRAME_BITS  = 16,
  parameter int DATA_BITS   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  input  logic        dac_clr_n,
  input  logic        dac_ldac_n,
  output logic [11:0] ast_source_data,
  output logic        ast_source_valid,
  output logic [1:0]  ast_source_error,
  output logic [3:0]  cmd,
  output logic        overrun
);

  localparam int CMD_BITS = FRAME_BITS - DATA_BITS;
  localparam int CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_BITS + 1);
  localparam int FLUSH_W  = SYNC_STAGES + 2;

  // Pin bundle positions; control pins idle high, so they reset high.
  localparam int P_SCLK = 0, P_MOSI = 1, P_CS = 2, P_CLR = 3, P_LDAC = 4;
  localparam logic [4:0] PIN_RST = 5'b11100;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  logic [4:0]                  lvl_q, lvl_d;
  logic [4:0]                  pins, synced;
  logic                        sclk_rise_q, cs_fall_q, cs_rise_q, ldac_fall_q, clr_fall_q;
  logic                        sclk_rise_d, cs_fall_d, cs_rise_d, ldac_fall_d, clr_fall_d;
  logic [FLUSH_W-1:0]          flush_q, flush_d;
  state_t                      state_q, state_d;
  logic [FRAME_BITS-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [DATA_BITS-1:0]        in_q, in_d, out_q, out_d;
  logic                        pend_q, pend_d, ovr_q, ovr_d;
  logic [CMD_BITS-1:0]         cmd_q, cmd_d;
  logic                        valid_q, valid_d;
  logic [1:0]                  err_q, err_d;
  logic                        accept, reject, load, clr_act;

  assign pins   = {dac_ldac_n, dac_clr_n, spi_cs_n, spi_mosi, spi_sclk};
  assign synced = sync_q[SYNC_STAGES-1];

  // Next-state logic: synchronizers, edge stage, frame FSM and DAC latches.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], pins};
    lvl_d       = synced;
    sclk_rise_d =  synced[P_SCLK] & ~lvl_q[P_SCLK];
    cs_fall_d   = ~synced[P_CS]   &  lvl_q[P_CS];
    cs_rise_d   =  synced[P_CS]   & ~lvl_q[P_CS];
    ldac_fall_d = ~synced[P_LDAC] &  lvl_q[P_LDAC];
    clr_fall_d  = ~synced[P_CLR]  &  lvl_q[P_CLR];
    // The synchronizers reset to idle-high, so cs_n reads high for a few
    // cycles after reset whatever the pin does; wait for them to flush.
    flush_d     = {flush_q[FLUSH_W-2:0], 1'b1};

    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      WAIT_IDLE: if (flush_q[FLUSH_W-1] && lvl_q[P_CS]) state_d = IDLE;
      IDLE: if (cs_fall_q) begin
        state_d = SHIFT;
        shift_d = '0;
        cnt_d   = '0;
      end
      SHIFT: begin
        if (sclk_rise_q) begin
          shift_d = {shift_q[FRAME_BITS-2:0], lvl_q[P_MOSI]};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
        if (cs_rise_q) begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL) accept = 1'b1;
          else                   reject = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    // Edge flags and levels in lvl_q are aligned: both describe the same cycle.
    clr_act = ~lvl_q[P_CLR];
    load    = (ldac_fall_q & pend_q) | (accept & ~lvl_q[P_LDAC]);

    in_d   = in_q;
    out_d  = out_q;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    cmd_d  = cmd_q;
    if (accept) begin
      in_d   = shift_q[DATA_BITS-1:0];
      cmd_d  = shift_q[FRAME_BITS-1:DATA_BITS];
      pend_d = 1'b1;
      if (pend_q) ovr_d = 1'b1;
    end
    // A tied-low load takes the frame being accepted this cycle.
    if (load) begin
      out_d  = accept ? shift_q[DATA_BITS-1:0] : in_q;
      pend_d = 1'b0;
    end
    if (clr_act) begin
      in_d   = '0;
      out_d  = '0;
      pend_d = 1'b0;
    end

    valid_d = 1'b0;
    err_d   = 2'b00;
    if (clr_fall_q) begin
      valid_d = 1'b1;
      err_d   = 2'b10;
    end else if (reject) begin
      valid_d = 1'b1;
      err_d   = 2'b01;
    end else if (load && !clr_act) begin
      valid_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= {SYNC_STAGES{PIN_RST}};
      lvl_q       <= PIN_RST;
      sclk_rise_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      ldac_fall_q <= 1'b0;
      clr_fall_q  <= 1'b0;
      flush_q     <= '0;
      state_q     <= WAIT_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      in_q        <= '0;
      out_q       <= '0;
      pend_q      <= 1'b0;
      ovr_q       <= 1'b0;
      cmd_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      sync_q      <= sync_d;
      lvl_q       <= lvl_d;
      sclk_rise_q <= sclk_rise_d;
      cs_fall_q   <= cs_fall_d;
      cs_rise_q   <= cs_rise_d;
      ldac_fall_q <= ldac_fall_d;
      clr_fall_q  <= clr_fall_d;
      flush_q     <= flush_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      in_q        <= in_d;
      out_q       <= out_d;
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      cmd_q       <= cmd_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign ast_source_data  = out_q;
  assign ast_source_valid = valid_q;
  assign ast_source_error = err_q;
  assign cmd              = cmd_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Bench for dac_spi_receiver: directed frames and control-pin events, a
// transaction-level DAC model that predicts every valid pulse (data, error,
// cycle), and a per-cycle compare process against that prediction.
module tb_dac_spi_receiver;
  localparam int LAT = 2 + 2;  // SYNC_STAGES + 2

  logic clk = 1'b0, reset = 1'b1;
  logic spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic dac_clr_n = 1'b1, dac_ldac_n = 1'b1;
  logic [11:0] ast_source_data;
  logic        ast_source_valid;
  logic [1:0]  ast_source_error;
  logic [3:0]  cmd;
  logic        overrun;

  dac_spi_receiver dut (
    .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .dac_clr_n(dac_clr_n), .dac_ldac_n(dac_ldac_n),
    .ast_source_data(ast_source_data), .ast_source_valid(ast_source_valid),
    .ast_source_error(ast_source_error), .cmd(cmd), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [11:0] data; logic [1:0] err; int at; } exp_t;
  exp_t q[$];
  int n_tests = 0, n_fail = 0;

  // DAC model state
  logic [11:0] m_in = '0, m_out = '0;
  logic [3:0]  m_cmd = '0;
  bit          m_pend = 0, m_ovr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] d, input logic [1:0] e);
    exp_t x;
    x.data = d; x.err = e; x.at = cyc + LAT;
    q.push_back(x);
  endtask

  task automatic model_reset();
    m_in = '0; m_out = '0; m_cmd = '0; m_pend = 0; m_ovr = 0;
  endtask

  // Frame ends with cs_n rising: accept exactly 16 bits, else framing error.
  task automatic model_frame_end(input logic [16:0] bits, input int n, input bit ldac_low);
    if (n == 16) begin
      m_cmd = bits[15:12];
      m_in  = bits[11:0];
      if (ldac_low) begin
        m_out = bits[11:0];
        m_pend = 0;
        push(m_out, 2'b00);
      end else begin
        if (m_pend) m_ovr = 1;
        m_pend = 1;
      end
    end else begin
      push(m_out, 2'b01);
    end
  endtask

  task automatic shift_bits(input logic [16:0] bits, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      spi_mosi = bits[i];
      tick(2);
      spi_sclk = 1'b1;
      tick(2);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [16:0] bits, input int n);
    spi_cs_n = 1'b0;
    tick(3);
    shift_bits(bits, n - 1, 0);
    tick(2);
    spi_cs_n = 1'b1;
    model_frame_end(bits, n, dac_ldac_n == 1'b0);
    tick(12);
  endtask

  task automatic ldac_pulse();
    dac_ldac_n = 1'b0;
    if (m_pend) begin
      m_out = m_in;
      m_pend = 0;
      push(m_out, 2'b00);
    end
    tick(4);
    dac_ldac_n = 1'b1;
    tick(10);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cmd"}, 32'(cmd), 32'(m_cmd));
    chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, "_data"}, 32'(ast_source_data), 32'(m_out));
  endtask

  // Every valid pulse must match the next predicted one, on its predicted cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (ast_source_valid) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_valid: got data=%0h err=%0h expected no pulse (cyc %0d)",
                   ast_source_data, ast_source_error, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_cycle", 32'(cyc), 32'(e.at));
          chk("pulse_data", 32'(ast_source_data), 32'(e.data));
          chk("pulse_err", 32'(ast_source_error), 32'(e.err));
        end
      end else if (q.size() > 0 && cyc > q[0].at) begin
        n_tests++; n_fail++;
        $display("FAIL missing_valid: got none expected data=%0h err=%0h at cyc %0d",
                 q[0].data, q[0].err, q[0].at);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick(8);
    chk("rst_data", 32'(ast_source_data), 32'h0);
    chk("rst_valid", 32'(ast_source_valid), 32'h0);
    chk("rst_err", 32'(ast_source_error), 32'h0);
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);

    // Short and long frames: framing errors, nothing latched.
    frame(17'h07BCD, 15);
    frame(17'h1FFFF, 17);
    check_state("len_err");
    chk("len_err_cmd_lit", 32'(cmd), 32'h0);
    chk("len_err_data_lit", 32'(ast_source_data), 32'h0);

    // Frame with ldac_n high, then a ldac_n pulse.
    frame(17'h03A5C, 16);
    chk("frame1_cmd_lit", 32'(cmd), 32'h3);
    ldac_pulse();
    chk("frame1_data_lit", 32'(ast_source_data), 32'hA5C);

    // ldac_n tied low: each frame loads straight through.
    dac_ldac_n = 1'b0;
    tick(6);
    frame(17'h00123, 16);
    frame(17'h00FFF, 16);
    dac_ldac_n = 1'b1;
    tick(6);
    chk("tied_data_lit", 32'(ast_source_data), 32'hFFF);
    chk("tied_overrun_lit", 32'(overrun), 32'h0);
    check_state("tied");

    // Two frames without ldac: overrun, then the later frame loads.
    frame(17'h01111, 16);
    frame(17'h02222, 16);
    chk("ovr_set_lit", 32'(overrun), 32'h1);
    ldac_pulse();
    chk("ovr_data_lit", 32'(ast_source_data), 32'h222);
    chk("ovr_sticky_lit", 32'(overrun), 32'h1);

    // Clear and ldac fall in the same clk while pending.
    frame(17'h04321, 16);
    dac_clr_n = 1'b0;
    dac_ldac_n = 1'b0;
    push(12'h000, 2'b10);
    m_in = '0; m_out = '0; m_pend = 0;
    tick(6);
    dac_ldac_n = 1'b1;
    tick(4);
    dac_clr_n = 1'b1;
    tick(8);
    ldac_pulse();
    check_state("clr");
    chk("clr_data_lit", 32'(ast_source_data), 32'h0);

    // Reset in the middle of a frame (after bit 7), released with cs_n low.
    spi_cs_n = 1'b0;
    tick(3);
    shift_bits(17'h00800, 15, 7);
    reset = 1'b1;
    model_reset();
    tick(3);
    chk("midrst_overrun_lit", 32'(overrun), 32'h0);
    reset = 1'b0;
    shift_bits(17'h00800, 6, 0);
    tick(2);
    spi_cs_n = 1'b1;
    tick(12);
    dac_ldac_n = 1'b0;
    tick(6);
    frame(17'h00800, 16);
    dac_ldac_n = 1'b1;
    tick(6);
    check_state("midrst");
    chk("midrst_data_lit", 32'(ast_source_data), 32'h800);

    tick(10);
    chk("pending_pulses", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
